memory_r: RTL and testbench
===========================

Name: memory_r

Overview:
- Byte-addressed, little-endian read port: the load-side counterpart of the team's memory write block.
- Serves JVM-style loads: baload/caload/saload/iaload map to byte, half and word reads, with optional sign extension.
- Uses the same start/ready handshake and the same address-dependent pseudo-random latency as the write side.
- Includes a byte backdoor load port so the array can be preloaded by the bench or by the loader.

Parameters:
- SIZE, 256: number of byte cells in the array.
- ADDRESS_WIDTH, 8: width of the address and load_addr ports.
- READ_SIZE, 32: width of data_out. Fixed at 32.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- address, input, ADDRESS_WIDTH: byte address of the read; captured on accept.
- start, input, 1: read request; accepted only when ready=1.
- size, input, 2: access size. 00=byte, 01=half, 10=word, 11=reserved (treated as word).
- sign_ext, input, 1: 1 = sign-extend byte/half results; 0 = zero-extend.
- ready, output, 1: high when idle and able to accept start.
- valid, output, 1: one-cycle pulse; data_out is new this cycle.
- data_out, output, READ_SIZE: read result; held until the next completion.
- load_en, input, 1: backdoor byte write enable.
- load_addr, input, ADDRESS_WIDTH: backdoor byte address.
- load_data, input, 8: backdoor byte value.

Behaviour:
- Reset (sampled at the clk edge while reset=1):
  - all SIZE cells cleared to 0, indices 0..SIZE-1 inclusive;
  - state=IDLE, ready=1, valid=0, data_out=0, latched fields cleared;
  - reset takes priority over start and load_en.
- States: IDLE, WAIT.
- IDLE:
  - On an edge with start=1, latch ad_t = address mod SIZE, size, sign_ext, and counter = address[1:0]; go to WAIT.
  - ready falls after that edge.
- WAIT with counter != 0: decrement counter each edge.
- WAIT with counter == 0: on that edge,
  - read the array, assemble and register data_out;
  - set valid=1 for one cycle;
  - return to IDLE, ready=1.
- Latency: accept edge E0; completion at edge E(address[1:0]+1). valid is therefore high during cycle 1..4 after accept.
- start while ready=0 is ignored, not queued.
- A start in the same cycle valid=1 is accepted; back-to-back reads are legal.
- Assembly, with b_k = array[(ad_t+k) mod SIZE]:
  - word: {b3,b2,b1,b0};
  - half: {ext16, b1, b0};
  - byte: {ext24, b0};
  - ext = replicated MSB of the selected data when sign_ext=1, else zeros.
- Wrap-around: byte indices wrap modulo SIZE. No alignment requirement; unaligned accesses are legal.
- Load port:
  - independent of the FSM; writes array[load_addr mod SIZE] <= load_data on any edge with load_en=1;
  - legal in any state.
- Load/read ordering:
  - The array is sampled at the completion edge.
  - A load on an earlier edge is visible to the read.
  - A load on the same edge is not visible: the read returns the old byte.
- Reset mid-WAIT: the read is aborted, no valid pulse, and the array is cleared.

Decomposition:
- Package memory_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state encoding ST_IDLE, ST_WAIT;
  - the default SIZE/ADDRESS_WIDTH constants, shared with the write block.
- One combinational sub-module, load_extend:
  - inputs: raw 32-bit little-endian bytes, size, sign_ext;
  - output: the 32-bit result.
- The FSM, counter and array stay in memory_r.

Test Plan:
- Reset, then word read at address 0x00 -> ready drops for 1 cycle; valid in cycle 1 after accept; data_out=0x00000000.
- Load bytes 0x10..0x13 = 0x11,0x22,0x33,0x84; word read at 0x13 -> valid in cycle 4 after accept; data_out = {array[0x16],array[0x15],array[0x14],0x84}.
- Same load, then byte read at 0x13:
  - sign_ext=1 -> data_out=0xFFFFFF84;
  - sign_ext=0 -> 0x00000084.
- Half read at 0x12 with sign_ext=1 -> 0xFFFF8433.
- Load 0xFF=0xAA and 0x00=0xBB; word read at 0xFF -> byte0=0xAA, byte1=0xBB (wraps to index 0).
- Ordering and reset, across three separate reads:
  - start pulsed during WAIT -> ignored, exactly one valid pulse;
  - load to the read byte on the completion edge -> old value returned;
  - reset asserted mid-WAIT -> no valid pulse, ready=1, subsequent read returns 0.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared constants for the byte-addressed memory blocks: default geometry,
// access-size encodings and the request FSM states.
package memory_pkg;

    localparam int unsigned MEM_SIZE          = 256;
    localparam int unsigned MEM_ADDRESS_WIDTH = 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

endpackage

// File: rtl/load_extend.sv
// Narrows raw little-endian bytes to the requested access size and applies
// sign or zero extension; a reserved size code reads as a full word.
module load_extend
    import memory_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] result
);

    logic byte_msb;
    logic half_msb;

    assign byte_msb = sign_ext & raw[7];
    assign half_msb = sign_ext & raw[15];

    always_comb begin
        result = raw;
        case (size)
            SZ_BYTE: result = {{24{byte_msb}}, raw[7:0]};
            SZ_HALF: result = {{16{half_msb}}, raw[15:0]};
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/memory_r.sv
// Load-side memory port: start/ready handshake, address-dependent latency,
// wrap-around little-endian assembly and an independent byte backdoor.
module memory_r
    import memory_pkg::*;
#(
    parameter int unsigned SIZE          = MEM_SIZE,
    parameter int unsigned ADDRESS_WIDTH = MEM_ADDRESS_WIDTH,
    parameter int unsigned READ_SIZE     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic                     start,
    input  logic [1:0]               size,
    input  logic                     sign_ext,
    output logic                     ready,
    output logic                     valid,
    output logic [READ_SIZE-1:0]     data_out,
    input  logic                     load_en,
    input  logic [ADDRESS_WIDTH-1:0] load_addr,
    input  logic [7:0]               load_data
);

    localparam int unsigned IDX_W = $clog2(SIZE);

    function automatic logic [IDX_W-1:0] mod_idx(input logic [31:0] val);
        return IDX_W'(val % 32'(SIZE));
    endfunction

    logic [7:0]       mem [SIZE];
    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] ad_t;
    logic [1:0]       sz_q;
    logic             sign_q;
    logic [1:0]       counter;
    logic [31:0]      raw;
    logic [31:0]      ext_data;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (counter == 2'd0) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Array is read combinationally before the edge, so a backdoor load
    // landing on the completion edge is not seen by that read.
    always_comb begin
        raw = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            raw[8*k +: 8] = mem[mod_idx(32'(ad_t) + 32'(k))];
        end
    end

    load_extend u_extend (
        .raw      (raw),
        .size     (sz_q),
        .sign_ext (sign_q),
        .result   (ext_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < SIZE; i++) begin
                mem[i] <= '0;
            end
            ad_t     <= '0;
            sz_q     <= '0;
            sign_q   <= 1'b0;
            counter  <= '0;
            valid    <= 1'b0;
            data_out <= '0;
        end else begin
            if (load_en) mem[mod_idx(32'(load_addr))] <= load_data;
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ad_t    <= mod_idx(32'(address));
                        sz_q    <= size;
                        sign_q  <= sign_ext;
                        counter <= address[1:0];
                    end
                end
                ST_WAIT: begin
                    if (counter != 2'd0) begin
                        counter <= counter - 2'd1;
                    end else begin
                        data_out <= ext_data;
                        valid    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_r.sv
// Directed bench for memory_r: vector table of reads over a preloaded array,
// plus sequences for ignored starts, same-edge loads and reset mid-read.
module tb_memory_r;
    import memory_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  address;
    logic        start;
    logic [1:0]  size;
    logic        sign_ext;
    logic        ready;
    logic        valid;
    logic [31:0] data_out;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [7:0]  load_data;

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    memory_r #(.SIZE(256), .ADDRESS_WIDTH(8), .READ_SIZE(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .start     (start),
        .size      (size),
        .sign_ext  (sign_ext),
        .ready     (ready),
        .valid     (valid),
        .data_out  (data_out),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] exp;
        int unsigned lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    // Issues one read and returns data and the edge count from accept to valid (0 = timeout).
    task automatic do_read(input logic [7:0] a, input logic [1:0] sz, input logic sx,
                           output logic [31:0] d, output int unsigned lat);
        int unsigned w;
        w = 0;
        while (!ready && w < 20) begin
            tick();
            w++;
        end
        address  = a;
        size     = sz;
        sign_ext = sx;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("ready_low_after_accept", 32'(ready), 32'd0);
        lat = 0;
        d   = '0;
        for (int unsigned n = 1; n <= 8; n++) begin
            if (lat == 0) begin
                tick();
                if (valid) begin
                    lat = n;
                    d   = data_out;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        int unsigned lat;
        int unsigned pulses;

        vecs[0]  = '{8'h13, SZ_WORD, 1'b0, 32'h77665584, 4};
        vecs[1]  = '{8'h13, SZ_BYTE, 1'b1, 32'hFFFFFF84, 4};
        vecs[2]  = '{8'h13, SZ_BYTE, 1'b0, 32'h00000084, 4};
        vecs[3]  = '{8'h12, SZ_HALF, 1'b1, 32'hFFFF8433, 3};
        vecs[4]  = '{8'h12, SZ_HALF, 1'b0, 32'h00008433, 3};
        vecs[5]  = '{8'hFF, SZ_WORD, 1'b0, 32'hDDCCBBAA, 4};
        vecs[6]  = '{8'h10, SZ_WORD, 1'b1, 32'h84332211, 1};
        vecs[7]  = '{8'h11, 2'b11,   1'b1, 32'h55843322, 2};
        vecs[8]  = '{8'h14, SZ_BYTE, 1'b1, 32'h00000055, 1};
        vecs[9]  = '{8'h11, SZ_HALF, 1'b1, 32'h00003322, 2};
        vecs[10] = '{8'h15, SZ_HALF, 1'b0, 32'h00007766, 2};
        vecs[11] = '{8'h13, SZ_HALF, 1'b0, 32'h00005584, 4};

        reset = 1'b1; start = 1'b0; address = '0; size = '0; sign_ext = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_data", data_out, 32'd0);

        do_read(8'h00, SZ_WORD, 1'b0, d, lat);
        check("rd0_data", d, 32'h0);
        check("rd0_lat", lat, 32'd1);
        check("rd0_ready_back", 32'(ready), 32'd1);

        load_byte(8'h10, 8'h11); load_byte(8'h11, 8'h22);
        load_byte(8'h12, 8'h33); load_byte(8'h13, 8'h84);
        load_byte(8'h14, 8'h55); load_byte(8'h15, 8'h66);
        load_byte(8'h16, 8'h77); load_byte(8'hFF, 8'hAA);
        load_byte(8'h00, 8'hBB); load_byte(8'h01, 8'hCC);
        load_byte(8'h02, 8'hDD);

        for (int unsigned i = 0; i < 12; i++) begin
            do_read(vecs[i].addr, vecs[i].sz, vecs[i].sx, d, lat);
            check($sformatf("vec%0d_data", i), d, vecs[i].exp);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            tick();
            check($sformatf("vec%0d_valid_one_cycle", i), 32'(valid), 32'd0);
        end

        // Starts raised while waiting must be dropped, not queued.
        address = 8'h13; size = SZ_WORD; sign_ext = 1'b0; start = 1'b1;
        tick();
        start   = 1'b0;
        address = 8'h10;
        pulses  = 0;
        d       = '0;
        for (int unsigned i = 1; i <= 12; i++) begin
            tick();
            if (valid) begin
                pulses++;
                d = data_out;
            end
            start = (i <= 2);
        end
        check("busy_start_pulses", pulses, 32'd1);
        check("busy_start_data", d, 32'h77665584);

        // Backdoor write on the completion edge returns the old byte.
        address = 8'h10; size = SZ_BYTE; sign_ext = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        load_en = 1'b1; load_addr = 8'h10; load_data = 8'h5A;
        tick();
        load_en = 1'b0;
        check("same_edge_valid", 32'(valid), 32'd1);
        check("same_edge_old_data", data_out, 32'h00000011);
        do_read(8'h10, SZ_BYTE, 1'b0, d, lat);
        check("later_load_visible", d, 32'h0000005A);

        // Reset in the middle of a read aborts it and clears the array.
        address = 8'h13; size = SZ_WORD; sign_ext = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_ready", 32'(ready), 32'd1);
        check("midreset_data", data_out, 32'd0);
        pulses = 0;
        if (valid) pulses++;
        for (int unsigned i = 0; i < 6; i++) begin
            tick();
            if (valid) pulses++;
        end
        check("midreset_no_valid", pulses, 32'd0);
        do_read(8'h13, SZ_WORD, 1'b0, d, lat);
        check("midreset_cleared_data", d, 32'h0);
        check("midreset_cleared_lat", lat, 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
